// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared defaults, FSM state encoding and reset-state convention for icache_dm
package icache_dm_pkg;
    localparam int LINES_DEF = 64;
    localparam int LINE_BEATS_DEF = 4;
    localparam int ADDR_W = 32;
    typedef enum logic [2:0] {INIT, IDLE, REFILL_REQ, REFILL_DATA, RESP} state_t;
    localparam state_t RESET_STATE = INIT;
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-bus-side signals of the instruction cache
interface icache_dm_if;
    logic [63:0] im_req_addr;
    logic im_req_valid;
    logic im_req_ready;
    logic [63:0] im_resp_rdata;
    logic im_resp_valid;
    logic invalidate;
    logic [63:0] mem_req_addr;
    logic mem_req_valid;
    logic mem_req_ready;
    logic [63:0] mem_resp_rdata;
    logic mem_resp_valid;
    modport slave (
        input im_req_addr, im_req_valid, invalidate, mem_req_ready, mem_resp_rdata, mem_resp_valid,
        output im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
    );
    modport master (
        output im_req_addr, im_req_valid, invalidate, mem_req_ready, mem_resp_rdata, mem_resp_valid,
        input im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
    );
endinterface

// File: rtl/icache_dm_ram_sp_sync.sv
// ram_sp_sync: synchronous-read RAM with an independent write port
module ram_sp_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with burst line refill and fence.i invalidation
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int LINE_BEATS = LINE_BEATS_DEF
) (
    input logic clk,
    input logic rst,
    icache_dm_if.slave bus
);
    localparam int OFF_W = $clog2(8 * LINE_BEATS);
    localparam int IDX_W = $clog2(LINES);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    state_t state, next;
    logic [IDX_W-1:0] sweep;
    logic [BEAT_W-1:0] beat;
    logic [31:3] addr_q;
    logic pend, inv_pend;
    logic [63:0] word;
    logic [TAG_W:0] tag_q, tag_wdata;
    logic [IDX_W-1:0] tag_waddr;
    logic tag_we;
    logic [63:0] data_q;
    logic ready, resp_v;
    logic unused_bits;

    wire [TAG_W-1:0] req_tag = addr_q[31 -: TAG_W];
    wire [IDX_W-1:0] req_idx = addr_q[OFF_W +: IDX_W];
    wire [BEAT_W-1:0] req_beat = addr_q[3 +: BEAT_W];
    wire [IDX_W-1:0] in_idx = bus.im_req_addr[OFF_W +: IDX_W];
    wire [BEAT_W-1:0] in_beat = bus.im_req_addr[3 +: BEAT_W];
    wire hit = pend && tag_q[TAG_W] && tag_q[TAG_W-1:0] == req_tag;
    wire accept = bus.im_req_valid && ready;
    wire beat_in = state == REFILL_DATA && bus.mem_resp_valid;
    wire last = beat_in && beat == BEAT_W'(LINE_BEATS - 1);

    assign unused_bits = ^{bus.im_req_addr[63:32], bus.im_req_addr[2:0]};

    ram_sp_sync #(.WIDTH(TAG_W + 1), .DEPTH(LINES)) u_tag (
        .clk(clk), .we(tag_we), .waddr(tag_waddr), .wdata(tag_wdata),
        .raddr(in_idx), .rdata(tag_q)
    );

    ram_sp_sync #(.WIDTH(64), .DEPTH(LINES * LINE_BEATS)) u_data (
        .clk(clk), .we(beat_in), .waddr({req_idx, beat}), .wdata(bus.mem_resp_rdata),
        .raddr({in_idx, in_beat}), .rdata(data_q)
    );

    always_comb begin
        next = state;
        tag_we = 1'b0;
        tag_waddr = req_idx;
        tag_wdata = {1'b1, req_tag};
        ready = 1'b0;
        resp_v = 1'b0;
        case (state)
            INIT: begin
                tag_we = 1'b1;
                tag_waddr = sweep;
                tag_wdata = '0;
                next = sweep == IDX_W'(LINES - 1) ? IDLE : INIT;
            end
            IDLE: begin
                resp_v = hit;
                ready = !inv_pend && (!pend || hit);
                // a lookup in flight finishes before an invalidate sweep starts
                next = pend && !hit ? REFILL_REQ :
                       (inv_pend || bus.invalidate) && !accept ? INIT : IDLE;
            end
            REFILL_REQ: next = bus.mem_req_ready ? REFILL_DATA : REFILL_REQ;
            REFILL_DATA: begin
                tag_we = last;
                next = last ? RESP : REFILL_DATA;
            end
            RESP: begin
                resp_v = 1'b1;
                next = IDLE;
            end
            default: next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
            sweep <= '0;
            beat <= '0;
            pend <= 1'b0;
            inv_pend <= 1'b0;
        end else begin
            state <= next;
            sweep <= state == INIT ? sweep + IDX_W'(1) : '0;
            beat <= state == REFILL_DATA ? beat + BEAT_W'(bus.mem_resp_valid) : '0;
            pend <= accept;
            inv_pend <= next == INIT ? 1'b0 : inv_pend || (bus.invalidate && state != INIT);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) addr_q <= bus.im_req_addr[31:3];
        if (beat_in && beat == req_beat) word <= bus.mem_resp_rdata;
    end

    assign bus.im_req_ready = ready;
    assign bus.im_resp_valid = resp_v;
    assign bus.im_resp_rdata = state == RESP ? word : data_q;
    assign bus.mem_req_valid = state == REFILL_REQ;
    assign bus.mem_req_addr = {32'b0, addr_q[31:OFF_W], {OFF_W{1'b0}}};
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed fetch sequences against a bus model, responses checked by a scoreboard monitor
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_dm_if bus();
    icache_dm dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] exp_q[$];
    logic [63:0] exp_m[$];
    int checks = 0;
    int errors = 0;
    int req_stall = 0;
    int beat_gap = 0;
    int bus_beat = 0;

    function automatic logic [63:0] mdata(input logic [63:0] a);
        logic [31:0] w;
        w = {a[31:3], 3'b000};
        return {~w, w};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic push, output int waited);
        int n = 0;
        bus.im_req_valid = 1'b1;
        bus.im_req_addr = a;
        while (!bus.im_req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: addr %h never accepted", a);
        end
        if (push) exp_q.push_back(mdata(a));
        waited = n;
        @(negedge clk);
        bus.im_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (bus_beat < k && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", bus_beat, k);
        end
    endtask

    // response scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.im_resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h expected no response", bus.im_resp_rdata);
                end else check("resp_data", bus.im_resp_rdata, exp_q.pop_front());
            end
        end
    end

    // memory bus model: optional request stall, gapped beats in ascending order
    initial begin
        int st = 0;
        int cnt = 0;
        int bi = 0;
        logic [63:0] la = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (rst) begin
                st = 0;
                cnt = 0;
            end else if (st == 0 && bus.mem_req_valid) begin
                if (cnt < req_stall) cnt++;
                else begin
                    cnt = 0;
                    bus.mem_req_ready = 1'b1;
                    la = bus.mem_req_addr;
                    st = 1;
                    bi = 0;
                    bus_beat = 0;
                    if (exp_m.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: got %h expected none", la);
                    end else check("mem_req_addr", la, exp_m.pop_front());
                end
            end else if (st == 1) begin
                if (cnt < beat_gap) cnt++;
                else begin
                    cnt = 0;
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = mdata(la + 64'(bi * 8));
                    bi++;
                    bus_beat = bi;
                    if (bi == 4) st = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int w;
        bus.im_req_valid = 1'b0;
        bus.im_req_addr = '0;
        bus.invalidate = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.im_req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.im_resp_valid), 64'd0);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        rst = 1'b0;
        n = 0;
        while (!bus.im_req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("init_ready_low_cycles", 64'(n), 64'd64);

        exp_m.push_back(64'h8000_0000);
        issue(64'h8000_0000, 1'b1, w);
        issue(64'h8000_0008, 1'b1, w);
        issue(64'h8000_0010, 1'b1, w);
        check("stream_wait_2", 64'(w), 64'd0);
        issue(64'h8000_0018, 1'b1, w);
        check("stream_wait_3", 64'(w), 64'd0);
        wait_drain();

        exp_m.push_back(64'h8000_0800);
        issue(64'h8000_0800, 1'b1, w);
        exp_m.push_back(64'h8000_0000);
        issue(64'h8000_0000, 1'b1, w);
        issue(64'hFFFF_FFFF_8000_0008, 1'b1, w);
        wait_drain();

        bus_beat = 0;
        exp_m.push_back(64'h8000_1000);
        issue(64'h8000_1000, 1'b1, w);
        wait_beats(1);
        bus.invalidate = 1'b1;
        @(negedge clk);
        bus.invalidate = 1'b0;
        wait_drain();
        n = 0;
        while (!bus.im_req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("inval_ready_low_cycles", 64'(n), 64'd65);
        exp_m.push_back(64'h8000_1000);
        issue(64'h8000_1000, 1'b1, w);
        wait_drain();

        req_stall = 5;
        beat_gap = 3;
        exp_m.push_back(64'h8000_2040);
        issue(64'h8000_2050, 1'b1, w);
        n = 0;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
            if (bus.im_req_ready) n++;
        end
        check("stall_ready_high_cycles", 64'(n), 64'd0);
        req_stall = 0;
        beat_gap = 0;
        @(negedge clk);

        bus_beat = 0;
        exp_m.push_back(64'h8000_3000);
        issue(64'h8000_3008, 1'b0, w);
        wait_beats(2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_m.push_back(64'h8000_3000);
        issue(64'h8000_3008, 1'b1, w);
        issue(64'h8000_3018, 1'b1, w);
        wait_drain();

        check("resp_queue_left", 64'(exp_q.size()), 64'd0);
        check("mem_req_queue_left", 64'(exp_m.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
